// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator feeding an N-entry prefetch queue that reserves an
// entry per request, fills it on the in-order memory response and drops wrong-path responses.
module fetch_queue #(
    parameter int unsigned      DBITS        = 32,
    parameter int unsigned      INST_SIZE    = 4,
    parameter logic [DBITS-1:0] START_PC     = 'h40,
    parameter int unsigned      QUEUE_DEPTH  = 4,
    parameter int unsigned      PTR_BITS     = 2,
    parameter int unsigned      IMEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imemReqValid,
    output logic [DBITS-1:0] imemAddr,
    input  logic [DBITS-1:0] imemRdata,
    input  logic             imemRvalid,
    output logic             instValid,
    output logic [DBITS-1:0] instWord,
    output logic [DBITS-1:0] instPc,
    output logic [DBITS-1:0] instNextPc,
    input  logic             instReady,
    input  logic             redirectEn,
    input  logic [DBITS-1:0] redirectPc
);

    localparam int unsigned      CNT_BITS  = PTR_BITS + 1;
    // In-flight requests are bounded by the memory latency; the queue depth adds headroom.
    localparam int unsigned      DROP_BITS = $clog2(QUEUE_DEPTH + IMEM_LATENCY) + 1;
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(QUEUE_DEPTH);
    localparam logic [DBITS-1:0] PC_INC    = DBITS'(INST_SIZE);

    logic [DBITS-1:0]     r_fetch_pc;
    logic [PTR_BITS-1:0]  r_head;
    logic [PTR_BITS-1:0]  r_tail;
    logic [CNT_BITS-1:0]  r_count;
    logic [CNT_BITS-1:0]  r_nfill;
    logic [DROP_BITS-1:0] r_drop;
    logic [DBITS-1:0]     r_pc   [QUEUE_DEPTH];
    logic [DBITS-1:0]     r_word [QUEUE_DEPTH];

    logic                 w_fire;
    logic                 w_issue;
    logic                 w_resp_fill;
    logic                 w_resp_drop;
    logic [PTR_BITS-1:0]  w_fill_idx;
    logic [CNT_BITS-1:0]  w_unfilled;
    logic [DROP_BITS-1:0] w_drop_redirect;

    // Filled entries are always the oldest ones, so a fill count replaces per-entry flags.
    always_comb begin
        instValid       = !reset && (r_nfill != '0);
        instPc          = r_pc[r_head];
        instWord        = r_word[r_head];
        instNextPc      = r_pc[r_head] + PC_INC;
        w_fire          = instValid && instReady;
        w_issue         = !reset && !redirectEn && ((r_count != DEPTH_CNT) || w_fire);
        imemReqValid    = w_issue;
        imemAddr        = r_fetch_pc;
        w_resp_fill     = imemRvalid && (r_drop == '0);
        w_resp_drop     = imemRvalid && (r_drop != '0);
        w_fill_idx      = r_head + r_nfill[PTR_BITS-1:0];
        w_unfilled      = r_count - r_nfill;
        // A response arriving in the redirect cycle is itself wrong-path and is not counted.
        w_drop_redirect = r_drop + DROP_BITS'(w_unfilled) - DROP_BITS'(imemRvalid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= START_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_nfill    <= '0;
            r_drop     <= '0;
        end else if (redirectEn) begin
            r_fetch_pc <= redirectPc;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_nfill    <= '0;
            r_drop     <= w_drop_redirect;
        end else begin
            if (w_issue) begin
                r_tail     <= r_tail + 1'b1;
                r_fetch_pc <= r_fetch_pc + PC_INC;
            end
            if (w_fire) begin
                r_head <= r_head + 1'b1;
            end
            if (w_resp_drop) begin
                r_drop <= r_drop - 1'b1;
            end
            r_count <= r_count + CNT_BITS'(w_issue) - CNT_BITS'(w_fire);
            r_nfill <= r_nfill + CNT_BITS'(w_resp_fill) - CNT_BITS'(w_fire);
        end
    end

    // Entry payload needs no reset; occupancy counters qualify every read.
    always_ff @(posedge clk) begin
        if (!reset && !redirectEn) begin
            if (w_issue) begin
                r_pc[r_tail] <= r_fetch_pc;
            end
            if (w_resp_fill) begin
                r_word[w_fill_idx] <= imemRdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a latency-configurable in-order memory model and one task per
// scenario, each with hand-computed expected PCs, words and request addresses.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imemReqValid;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic        imemRvalid;
    logic        instValid;
    logic [31:0] instWord;
    logic [31:0] instPc;
    logic [31:0] instNextPc;
    logic        instReady;
    logic        redirectEn;
    logic [31:0] redirectPc;

    int          n_tests;
    int          n_fail;
    int          lat;
    int          mem_out;
    logic        pv [4];
    logic [31:0] pa [4];

    fetch_queue dut (
        .clk          (clk),
        .reset        (reset),
        .imemReqValid (imemReqValid),
        .imemAddr     (imemAddr),
        .imemRdata    (imemRdata),
        .imemRvalid   (imemRvalid),
        .instValid    (instValid),
        .instWord     (instWord),
        .instPc       (instPc),
        .instNextPc   (instNextPc),
        .instReady    (instReady),
        .redirectEn   (redirectEn),
        .redirectPc   (redirectPc)
    );

    always #5 clk = ~clk;

    // Memory contents differ from the address so word/PC mix-ups are visible.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic tick();
        logic        req;
        logic [31:0] addr;
        #1;
        req  = imemReqValid;
        addr = imemAddr;
        if (imemRvalid) assert (mem_out > 0) else $error("imemRvalid with no outstanding request");
        mem_out = mem_out + (req ? 1 : 0) - (imemRvalid ? 1 : 0);
        @(posedge clk);
        #1;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0]      = req;
        pa[0]      = addr;
        imemRvalid = pv[lat-1];
        imemRdata  = mem_word(pa[lat-1]);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        redirectEn = 1'b0;
        redirectPc = '0;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
        end
        imemRvalid = 1'b0;
        imemRdata  = '0;
        mem_out    = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        lat       = 1;
        instReady = 1'b1;
        do_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if (imemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_req got %b want 0", imemReqValid);
        end
        n_tests++;
        if (instValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", instValid);
        end
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if (imemReqValid !== 1'b1 || imemAddr !== 32'h40) begin
            n_fail++;
            $display("FAIL reset_first_req got %b/%h want 1/00000040", imemReqValid, imemAddr);
        end
        n_tests++;
        if (instValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_valid got %b want 0", instValid);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        lat       = 1;
        instReady = 1'b1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            #1;
            n_tests++;
            if (imemReqValid !== 1'b1 || imemAddr !== 32'h40 + 32'(4 * c)) begin
                n_fail++;
                $display("FAIL stream_req c=%0d got %b/%h want 1/%h", c, imemReqValid, imemAddr,
                         32'h40 + 32'(4 * c));
            end
            exp_pc = 32'h40 + 32'(4 * (c - 2));
            n_tests++;
            if (instValid !== (c >= 2) || (c >= 2 && (instPc !== exp_pc ||
                instWord !== mem_word(exp_pc) || instNextPc !== exp_pc + 32'd4))) begin
                n_fail++;
                $display("FAIL stream_out c=%0d got v=%b pc=%h w=%h np=%h want v=%b pc=%h",
                         c, instValid, instPc, instWord, instNextPc, c >= 2, exp_pc);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        lat       = 1;
        instReady = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            #1;
            n_tests++;
            if (imemReqValid !== (c < 4) || (c < 4 && imemAddr !== 32'h40 + 32'(4 * c))) begin
                n_fail++;
                $display("FAIL stall_req c=%0d got %b/%h want %b", c, imemReqValid, imemAddr, c < 4);
            end
            n_tests++;
            if (instValid !== (c >= 2) || (c >= 2 && instPc !== 32'h40)) begin
                n_fail++;
                $display("FAIL stall_head c=%0d got %b/%h want %b/00000040", c, instValid, instPc,
                         c >= 2);
            end
            tick();
        end
        instReady = 1'b1;
        for (int c = 10; c < 15; c++) begin
            #1;
            exp_pc = 32'h40 + 32'(4 * (c - 10));
            n_tests++;
            if (instValid !== 1'b1 || instPc !== exp_pc || instWord !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL release_head c=%0d got %b/%h/%h want 1/%h", c, instValid, instPc,
                         instWord, exp_pc);
            end
            n_tests++;
            if (imemReqValid !== 1'b1 || imemAddr !== 32'h50 + 32'(4 * (c - 10))) begin
                n_fail++;
                $display("FAIL release_req c=%0d got %b/%h want 1/%h", c, imemReqValid, imemAddr,
                         32'h50 + 32'(4 * (c - 10)));
            end
            tick();
        end
    endtask

    task automatic test_redirect_drop();
        lat       = 3;
        instReady = 1'b1;
        do_reset();
        for (int c = 0; c < 3; c++) tick();
        redirectEn = 1'b1;
        redirectPc = 32'h200;
        #1;
        n_tests++;
        if (imemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_redirect_req got %b want 0", imemReqValid);
        end
        tick();
        redirectEn = 1'b0;
        for (int c = 4; c < 10; c++) begin
            #1;
            n_tests++;
            if (imemReqValid !== 1'b1 || imemAddr !== 32'h200 + 32'(4 * (c - 4))) begin
                n_fail++;
                $display("FAIL drop_req c=%0d got %b/%h want 1/%h", c, imemReqValid, imemAddr,
                         32'h200 + 32'(4 * (c - 4)));
            end
            n_tests++;
            if (instValid !== (c >= 8) || (c >= 8 && (instPc !== 32'h200 + 32'(4 * (c - 8)) ||
                instWord !== mem_word(32'h200 + 32'(4 * (c - 8)))))) begin
                n_fail++;
                $display("FAIL drop_out c=%0d got v=%b pc=%h w=%h want v=%b", c, instValid, instPc,
                         instWord, c >= 8);
            end
            tick();
        end
    endtask

    task automatic test_redirect_handshake();
        lat       = 1;
        instReady = 1'b1;
        do_reset();
        for (int c = 0; c < 3; c++) tick();
        redirectEn = 1'b1;
        redirectPc = 32'h100;
        #1;
        n_tests++;
        if (instValid !== 1'b1 || instPc !== 32'h44 || imemReqValid !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_redirect got v=%b pc=%h req=%b want 1/00000044/0", instValid, instPc,
                     imemReqValid);
        end
        tick();
        redirectEn = 1'b0;
        for (int c = 4; c < 7; c++) begin
            #1;
            n_tests++;
            if (instValid !== (c == 6) || (c == 6 && (instPc !== 32'h100 ||
                instWord !== mem_word(32'h100)))) begin
                n_fail++;
                $display("FAIL hs_after c=%0d got v=%b pc=%h w=%h want v=%b pc=00000100", c,
                         instValid, instPc, instWord, c == 6);
            end
            n_tests++;
            if (imemReqValid !== 1'b1 || imemAddr !== 32'h100 + 32'(4 * (c - 4))) begin
                n_fail++;
                $display("FAIL hs_req c=%0d got %b/%h", c, imemReqValid, imemAddr);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        lat       = 3;
        instReady = 1'b1;
        do_reset();
        tick();
        tick();
        redirectEn = 1'b1;
        redirectPc = 32'h100;
        tick();
        redirectPc = 32'h300;
        tick();
        redirectEn = 1'b0;
        for (int c = 4; c < 12; c++) begin
            #1;
            n_tests++;
            if (imemReqValid !== 1'b1 || imemAddr !== 32'h300 + 32'(4 * (c - 4))) begin
                n_fail++;
                $display("FAIL b2b_req c=%0d got %b/%h want 1/%h", c, imemReqValid, imemAddr,
                         32'h300 + 32'(4 * (c - 4)));
            end
            n_tests++;
            if (instValid !== (c >= 8) || (c >= 8 && (instPc !== 32'h300 + 32'(4 * (c - 8)) ||
                instWord !== mem_word(32'h300 + 32'(4 * (c - 8)))))) begin
                n_fail++;
                $display("FAIL b2b_out c=%0d got v=%b pc=%h w=%h want v=%b", c, instValid, instPc,
                         instWord, c >= 8);
            end
            tick();
        end
    endtask

    task automatic test_wrap_reset();
        lat       = 1;
        instReady = 1'b1;
        do_reset();
        tick();
        redirectEn = 1'b1;
        redirectPc = 32'hFFFF_FFFC;
        tick();
        redirectEn = 1'b0;
        #1;
        n_tests++;
        if (imemReqValid !== 1'b1 || imemAddr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_req0 got %b/%h want 1/fffffffc", imemReqValid, imemAddr);
        end
        tick();
        #1;
        n_tests++;
        if (imemReqValid !== 1'b1 || imemAddr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_req1 got %b/%h want 1/00000000", imemReqValid, imemAddr);
        end
        tick();
        #1;
        n_tests++;
        if (instValid !== 1'b1 || instPc !== 32'hFFFF_FFFC || instNextPc !== 32'h0 ||
            instWord !== mem_word(32'hFFFF_FFFC)) begin
            n_fail++;
            $display("FAIL wrap_head got v=%b pc=%h np=%h w=%h want 1/fffffffc/00000000", instValid,
                     instPc, instNextPc, instWord);
        end
        tick();
        reset = 1'b1;
        #1;
        n_tests++;
        if (imemReqValid !== 1'b0 || instValid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold got req=%b v=%b want 0/0", imemReqValid, instValid);
        end
        tick();
        reset = 1'b0;
        #1;
        n_tests++;
        if (imemReqValid !== 1'b1 || imemAddr !== 32'h40 || instValid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_restart got req=%b a=%h v=%b want 1/00000040/0", imemReqValid,
                     imemAddr, instValid);
        end
        tick();
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        instReady  = 1'b0;
        redirectEn = 1'b0;
        redirectPc = '0;
        imemRvalid = 1'b0;
        imemRdata  = '0;
        n_tests    = 0;
        n_fail     = 0;
        lat        = 1;
        mem_out    = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_handshake();
        test_back_to_back();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
